branch_resolver: RTL

- Initiator and consumer for the registered ALU. It accepts one conditional-branch request (BEQ/BNE/BLT/BGE/BLTU/BGEU) at a time.
- For each request it drives the ALU twice: a SUB compare, then an ADD that forms the next PC. It reads back the ALU result/status and returns a single taken/target response over a valid/ready handshake.
- Sits between decode/issue and the PC update logic of the RV32I core.

---
 rtl/branch_resolver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Conditional-branch resolver for the RV32I core.
// Each branch uses the shared registered ALU twice: a SUB to compare, then an ADD to form the next PC.
module branch_resolver #(
  parameter int XLEN    = 32,
  parameter int SEQ_INC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      alu_status,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_taken,
  output logic [XLEN-1:0] resp_target,
  output logic            resp_illegal,
  output logic            resp_misaligned
);

  typedef enum logic [2:0] {IDLE, CMP, ADDR, CAPT, RESP} state_t;

  localparam logic [3:0]      OP_ADD  = 4'b0000;
  localparam logic [3:0]      OP_SUB  = 4'b1000;
  localparam logic [XLEN-1:0] INC_VAL = XLEN'(SEQ_INC);

  state_t          state;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic            taken_q;

  logic eq;
  logic sd;
  logic lt_s;
  logic lt_u;
  logic cond;

  // Carry, parity and overflow are meaningless for the SUB compare.
  logic unused_status;
  assign unused_status = ^{alu_status[4:3], alu_status[1:0]};

  // When the operand signs differ, the difference's sign bit can be wrong
  // (overflow), so the operand signs alone decide the ordering.
  always_comb begin
    eq   = alu_status[2];
    sd   = rs1_q[XLEN-1] ^ rs2_q[XLEN-1];
    lt_s = sd ? rs1_q[XLEN-1] : alu_result[XLEN-1];
    lt_u = sd ? rs2_q[XLEN-1] : alu_result[XLEN-1];
    cond = 1'b0;
    case (funct3_q)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

  // The ADDR operand B depends on this cycle's compare result, so the ALU drive is decoded from state.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    case (state)
      CMP: begin
        alu_a  = rs1_q;
        alu_b  = rs2_q;
        alu_op = OP_SUB;
      end
      ADDR: begin
        alu_a  = pc_q;
        alu_b  = cond ? imm_q : INC_VAL;
        alu_op = OP_ADD;
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
      end
    endcase
  end

  // Sequencer: one request in flight, response held until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_target     <= '0;
      resp_illegal    <= 1'b0;
      resp_misaligned <= 1'b0;
      funct3_q        <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      pc_q            <= '0;
      imm_q           <= '0;
      taken_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q  <= req_funct3;
            rs1_q     <= req_rs1;
            rs2_q     <= req_rs2;
            pc_q      <= req_pc;
            imm_q     <= req_imm;
            req_ready <= 1'b0;
            state     <= CMP;
          end
        end
        CMP: begin
          state <= ADDR;
        end
        ADDR: begin
          taken_q <= cond;
          state   <= CAPT;
        end
        CAPT: begin
          resp_target     <= alu_result;
          resp_taken      <= taken_q;
          resp_illegal    <= (funct3_q[2:1] == 2'b01);
          resp_misaligned <= taken_q & (|alu_result[1:0]);
          resp_valid      <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
